calc_secuenciador: RTL
======================

# calc_secuenciador

Operand-entry and execution sequencer for the 5-bit calculator. It takes the board slide switches and two push buttons, debounces the buttons, and walks the user through entering operand A, then operand B, then the operation code. It drives the calculator datapath inputs (a, b, sel0), waits for the combinational result to settle, and latches the 12-bit result for the LED and seven-segment display path.

## Interface
Parameters:
- DEB_CYCLES, 1000000: consecutive stable samples a button needs before its level is accepted (10 ms at 100 MHz). Benches override it to 4.
- SETTLE, 2: cycles spent in CALC before the result is captured. Legal range 1..15.

Ports:
- CLK_100MHz  in  1  system clock. All state changes on its rising edge.
- RST_n  in  1  asynchronous active-low reset.
- sw  in  5  slide switches, used for operand or op-code entry. Asynchronous; two-flop synchronized.
- btn_enter  in  1  raw "enter" push button, active-high.
- btn_clear  in  1  raw "clear" push button, active-high.
- result  in  12  datapath output (multiplexer result bus).
- a  out  5  registered operand A to the datapath.
- b  out  5  registered operand B to the datapath.
- sel0  out  3  registered operation select. Driven as the bitwise inverse of the op code, because the datapath select input is active-low.
- res_q  out  12  latched result for display.
- estado  out  3  current state encoding, shown on spare LEDs.
- done  out  1  one-cycle pulse when res_q is updated.
- err  out  1  high while the last op-code entry was invalid.

## Operation
Button conditioning (identical for both buttons):
- Two-flop synchronizer feeds a debounce counter.
- The counter resets whenever the synchronized sample differs from the accepted level.
- When the counter reaches DEB_CYCLES-1, the accepted level takes the sample value.
- A rising edge of the accepted level produces a one-cycle pulse: enter_p or clear_p.

State machine (estado encoding in brackets):
- CARGA_A [0]: on enter_p, a <= sw. Go to CARGA_B.
- CARGA_B [1]: on enter_p, b <= sw. Go to CARGA_OP.
- CARGA_OP [2]: on enter_p, read code = sw[2:0].
  - Code 0..6 (suma, resta, multip, comple_a, comple_b, conca, compara): sel0 <= ~code, err <= 0, go to CALC.
  - Code 7: err <= 1, stay in CARGA_OP, sel0 unchanged.
  - sw[4:3] are ignored.
- CALC [3]: settle counter counts SETTLE cycles. In the last cycle, res_q <= result and done pulses. Go to MOSTRAR.
- MOSTRAR [4]: hold all outputs. On enter_p, go to CARGA_A. a, b, sel0 and res_q keep their values until overwritten.
- Encodings 5..7 are unreachable. If ever entered, the next edge goes to CARGA_A.

Clear and precedence:
- clear_p in any state: go to CARGA_A and zero a, b, res_q and err. sel0 <= 3'b111. The settle counter resets.
- clear_p has priority over enter_p in the same cycle.
- enter_p is ignored in CALC. It is not queued.

## Timing
- Reset values: estado=0 (CARGA_A), a=0, b=0, sel0=3'b111, res_q=0, done=0, err=0.
- Reset also clears the synchronizers, debounce counters, accepted levels (0) and the settle counter.
- RST_n is asserted asynchronously and released synchronously to the existing logic; there is no internal reset synchronizer.
- Button latency: a clean press is seen on enter_p 2 (sync) + DEB_CYCLES cycles after the input rises.
- Register updates: if enter_p is high in cycle t, the register update and state change are visible at t+1.
- Result capture: CALC entered at cycle t; res_q updates and done=1 at t+SETTLE; estado=MOSTRAR at t+SETTLE.
- a, b and sel0 are stable for the whole CALC window.
- A button held indefinitely produces exactly one pulse. A bounce shorter than DEB_CYCLES produces no pulse.
- Reset asserted mid-CALC: no capture occurs and done stays 0.

## Test plan
- Full sequence with DEB_CYCLES=4, SETTLE=2:
  - Enter sw=5'd3, then 5'd4, then op 0; model result = a+b.
  - Required: a=3, b=4, sel0=3'b111, done pulses once, res_q=12'd7, estado=4.
- Bounce rejection: toggle btn_enter every 2 cycles for 20 cycles, then hold.
  - Required: exactly one enter_p, and it occurs 6 cycles after the final rise.
- Invalid op: in CARGA_OP enter code 7.
  - Required: err=1, estado stays 2, sel0 unchanged.
  - Then enter code 2. Required: err=0, sel0=3'b101, state goes to CALC.
- Clear precedence: press clear and enter in the same debounced cycle while in CARGA_B with a=9.
  - Required: estado=0, a=0, b=0, res_q=0, sel0=3'b111.
- Reset mid-operation: pull RST_n low during CALC, then release.
  - Required: outputs immediately take their reset values, done never pulses, and the next sequence works normally.
- Ignored enter in CALC: with SETTLE=8, pulse enter during CALC.
  - Required: capture still happens at t+8, estado=4, and no extra transition occurs.

Source files
------------

// File: rtl/calc_secuenciador_if.sv
// Board-side bundle of the calculator sequencer:
// switches, buttons, datapath result and the driven outputs.
interface calc_secuenciador_if;
  logic [4:0]  sw;
  logic        btn_enter;
  logic        btn_clear;
  logic [11:0] result;
  logic [4:0]  a;
  logic [4:0]  b;
  logic [2:0]  sel0;
  logic [11:0] res_q;
  logic [2:0]  estado;
  logic        done;
  logic        err;

  modport master (
    output sw, btn_enter, btn_clear, result,
    input  a, b, sel0, res_q, estado, done, err
  );

  modport slave (
    input  sw, btn_enter, btn_clear, result,
    output a, b, sel0, res_q, estado, done, err
  );
endinterface

// File: rtl/calc_secuenciador.sv
// Operand-entry sequencer for the 5-bit calculator:
// button debounce, A/B/op entry, settle wait and result latch.
module calc_secuenciador #(
  parameter int DEB_CYCLES = 1000000,
  parameter int SETTLE     = 2
) (
  input  logic CLK_100MHz,
  input  logic RST_n,
  calc_secuenciador_if.slave bus
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [3:0] SCNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    CARGA_A  = 3'd0,
    CARGA_B  = 3'd1,
    CARGA_OP = 3'd2,
    CALC     = 3'd3,
    MOSTRAR  = 3'd4
  } state_t;

  logic [4:0]    r_sw_s1;
  logic [4:0]    r_sw_s2;
  logic [1:0]    r_btn_s1;
  logic [1:0]    r_btn_s2;
  logic [1:0]    r_lvl;
  logic [1:0]    r_lvl_d;
  logic [CW-1:0] r_cnt_e;
  logic [CW-1:0] r_cnt_c;

  state_t        r_state;
  logic [4:0]    r_a;
  logic [4:0]    r_b;
  logic [2:0]    r_sel;
  logic [11:0]   r_res;
  logic          r_err;
  logic          r_done;
  logic [3:0]    r_scnt;

  state_t        w_state_nxt;
  logic [4:0]    w_a_nxt;
  logic [4:0]    w_b_nxt;
  logic [2:0]    w_sel_nxt;
  logic [11:0]   w_res_nxt;
  logic          w_err_nxt;
  logic          w_done_nxt;
  logic [3:0]    w_scnt_nxt;

  logic          w_enter_p;
  logic          w_clear_p;

  // Synchronize switches/buttons; debounce each button level
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_lvl    <= '0;
      r_lvl_d  <= '0;
      r_cnt_e  <= '0;
      r_cnt_c  <= '0;
    end else begin
      r_sw_s1  <= bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {bus.btn_clear, bus.btn_enter};
      r_btn_s2 <= r_btn_s1;
      r_lvl_d  <= r_lvl;
      if (r_btn_s2[0] == r_lvl[0]) begin
        r_cnt_e <= '0;
      end else if (r_cnt_e == CNT_MAX) begin
        r_lvl[0] <= r_btn_s2[0];
        r_cnt_e  <= '0;
      end else begin
        r_cnt_e <= r_cnt_e + 1'b1;
      end
      if (r_btn_s2[1] == r_lvl[1]) begin
        r_cnt_c <= '0;
      end else if (r_cnt_c == CNT_MAX) begin
        r_lvl[1] <= r_btn_s2[1];
        r_cnt_c  <= '0;
      end else begin
        r_cnt_c <= r_cnt_c + 1'b1;
      end
    end
  end

  assign w_enter_p = r_lvl[0] & ~r_lvl_d[0];
  assign w_clear_p = r_lvl[1] & ~r_lvl_d[1];

  // State and datapath register bank
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= CARGA_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= 3'b111;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_scnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_sel   <= w_sel_nxt;
      r_res   <= w_res_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
      r_scnt  <= w_scnt_nxt;
    end
  end

  // Next-state and register updates; clear wins over enter
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sel_nxt   = r_sel;
    w_res_nxt   = r_res;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    w_scnt_nxt  = '0;
    if (w_clear_p) begin
      w_state_nxt = CARGA_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_sel_nxt   = 3'b111;
      w_res_nxt   = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        CARGA_A: begin
          if (w_enter_p) begin
            w_a_nxt     = r_sw_s2;
            w_state_nxt = CARGA_B;
          end
        end
        CARGA_B: begin
          if (w_enter_p) begin
            w_b_nxt     = r_sw_s2;
            w_state_nxt = CARGA_OP;
          end
        end
        CARGA_OP: begin
          if (w_enter_p) begin
            if (r_sw_s2[2:0] == 3'd7) begin
              w_err_nxt = 1'b1;
            end else begin
              w_sel_nxt   = ~r_sw_s2[2:0];
              w_err_nxt   = 1'b0;
              w_state_nxt = CALC;
            end
          end
        end
        CALC: begin
          if (r_scnt == SCNT_LAST) begin
            w_res_nxt   = bus.result;
            w_done_nxt  = 1'b1;
            w_state_nxt = MOSTRAR;
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        MOSTRAR: begin
          if (w_enter_p) begin
            w_state_nxt = CARGA_A;
          end
        end
        default: begin
          w_state_nxt = CARGA_A;
        end
      endcase
    end
  end

  assign bus.a      = r_a;
  assign bus.b      = r_b;
  assign bus.sel0   = r_sel;
  assign bus.res_q  = r_res;
  assign bus.estado = r_state;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule
